fft_bfly_sched: RTL

//  Sequencer for the in-place radix-2 DIT FFT built around the shared 2-point butterfly.

---
 rtl/fft_bfly_sched_if.sv | 31 +++
 rtl/fft_bfly_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sched_if.sv
// Handshake and address bundle between the FFT butterfly scheduler and its consumers
// (sample RAM ports, twiddle ROM, top-level control).
interface fft_bfly_sched_if #(
    parameter int LOG2N = 3
);
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly read pair per cycle per stage,
// echoes the write pair LAT cycles later, drains between stages and pulses done at the end.
module fft_bfly_sched #(
    parameter int LOG2N = 3,
    parameter int LAT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    fft_bfly_sched_if.master    bus
);
    localparam int HALF_N = 1 << (LOG2N - 1);
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [LOG2N-2:0] K_LAST = (LOG2N-1)'(HALF_N - 1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(LAT - 1);

    logic [1:0]       state;
    logic [LOG2N-2:0] k;
    logic [LOG2N-1:0] stage;
    logic [CNT_W-1:0] drain_cnt;
    logic             done_r;
    logic             issue;

    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] addr_a_c;
    logic [LOG2N-1:0] addr_b_c;
    logic [LOG2N-2:0] tw_c;

    logic [LOG2N-1:0] ra_hold;
    logic [LOG2N-1:0] rb_hold;
    logic [LOG2N-2:0] tw_hold;
    logic [LOG2N-1:0] rd_a;
    logic [LOG2N-1:0] rd_b;

    logic             vld_p  [LAT];
    logic [LOG2N-1:0] wa_p   [LAT];
    logic [LOG2N-1:0] wb_p   [LAT];

    assign issue = (state == ISSUE);

    // Butterfly k of stage s: A gets a zero inserted at bit s, B is A with that bit set.
    always_comb begin
        kx       = LOG2N'(k);
        half     = LOG2N'(1) << stage;
        pos      = kx & (half - LOG2N'(1));
        addr_a_c = ((kx >> stage) << (stage + LOG2N'(1))) | pos;
        addr_b_c = addr_a_c + half;
        tw_c     = (LOG2N-1)'(pos << (S_LAST - stage));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            stage     <= '0;
            drain_cnt <= '0;
            done_r    <= 1'b0;
            ra_hold   <= '0;
            rb_hold   <= '0;
            tw_hold   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ISSUE;
                        k     <= '0;
                        stage <= '0;
                    end
                end
                ISSUE: begin
                    ra_hold <= addr_a_c;
                    rb_hold <= addr_b_c;
                    tw_hold <= tw_c;
                    if (k == K_LAST) begin
                        k         <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    // Hold off the next stage until its inputs have all been written back.
                    if (drain_cnt == D_LAST) begin
                        if (stage == S_LAST) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            stage <= stage + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    stage <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_a = issue ? addr_a_c : ra_hold;
    assign rd_b = issue ? addr_b_c : rb_hold;

    // Stage p0 captures the issued pair; stage p(LAT-1) drives the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                vld_p[i] <= 1'b0;
                wa_p[i]  <= '0;
                wb_p[i]  <= '0;
            end
        end else begin
            vld_p[0] <= issue;
            wa_p[0]  <= rd_a;
            wb_p[0]  <= rd_b;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                wa_p[i]  <= wa_p[i-1];
                wb_p[i]  <= wb_p[i-1];
            end
        end
    end

    assign bus.busy      = (state == ISSUE) || (state == DRAIN);
    assign bus.done      = done_r;
    assign bus.stage     = stage;
    assign bus.rd_en     = issue;
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_idx    = issue ? tw_c : tw_hold;
    assign bus.wr_en     = vld_p[LAT-1];
    assign bus.wr_addr_a = wa_p[LAT-1];
    assign bus.wr_addr_b = wb_p[LAT-1];
endmodule
